// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Iterative radix-2 shift-add multiply and restoring divide share one 2W-bit
// accumulator. Define MDU_FAST_MUL_EN to form the product combinationally
// (IDLE -> FIX in one edge); divide stays iterative either way.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] OperandA,
  input  logic [DATA_WIDTH-1:0] OperandB,
  input  logic                  HiLoRead,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Stall,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

`ifdef MDU_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ITER, FIX} stateType;

  stateType          state, nextState;
  logic [W-1:0]      magA, magB;      // operand magnitudes (magA holds raw A on divide-by-zero)
  logic [2*W-1:0]    acc;             // {partial high, multiplier} or {remainder, quotient}
  logic [CW-1:0]     count;
  logic              isDiv, divZero, negResult, negRem;

  // Issue-side decode of the request presented this cycle.
  logic         opMul, opDiv, opSigned, divZeroIn;
  logic         signA, signB;
  logic [W-1:0] absA, absB;

  assign opMul     = (Op == 3'd0) || (Op == 3'd1);
  assign opDiv     = (Op == 3'd2) || (Op == 3'd3);
  assign opSigned  = (Op == 3'd0) || (Op == 3'd2);
  assign divZeroIn = opDiv && (OperandB == '0);
  assign signA     = opSigned && OperandA[W-1];
  assign signB     = opSigned && OperandB[W-1];
  assign absA      = signA ? -OperandA : OperandA;
  assign absB      = signB ? -OperandB : OperandB;

  assign Busy  = (state != IDLE);
  assign Stall = Busy && (Start || HiLoRead);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic; Flush overrides everything.
  always_comb begin
    // NOTE: default assigned first so no path leaves nextState unassigned (no latch).
    nextState = state;
    if (Flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: if (Start && (opMul || opDiv))
                nextState = (divZeroIn || (opMul && FastMul)) ? FIX : ITER;
        ITER: if (count == CW'(1)) nextState = FIX;
        FIX:  nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  logic [W:0]     mulSum, divTrial;
  logic [2*W-1:0] accStep;
  always_comb begin
    mulSum   = {1'b0, acc[2*W-1:W]} + {1'b0, magA};
    // Shifted remainder is below 2*divisor, so W+1 bits hold it; bit W of the
    // difference is the borrow.
    divTrial = {acc[2*W-1:W], acc[W-1]} - {1'b0, magB};
    accStep  = acc;
    if (isDiv) begin
      if (!divTrial[W]) accStep = {divTrial[W-1:0], acc[W-2:0], 1'b1};
      else              accStep = {acc[2*W-2:0], 1'b0};
    end else begin
      if (acc[0]) accStep = {mulSum, acc[W-1:1]};
      else        accStep = {1'b0, acc[2*W-1:1]};
    end
  end

  // Final sign fix-up and HI/LO write values.
  logic [2*W-1:0] prodMag, product;
  logic [W-1:0]   quot, rem, hiNext, loNext;
  always_comb begin
`ifdef MDU_FAST_MUL_EN
    prodMag = {{W{1'b0}}, magA} * {{W{1'b0}}, magB};
`else
    prodMag = acc;
`endif
    product = negResult ? -prodMag : prodMag;
    quot    = negResult ? -acc[W-1:0] : acc[W-1:0];
    rem     = negRem ? -acc[2*W-1:W] : acc[2*W-1:W];
    if (divZero) begin
      hiNext = magA;
      loNext = '1;
    end else if (isDiv) begin
      hiNext = rem;
      loNext = quot;
    end else begin
      hiNext = product[2*W-1:W];
      loNext = product[W-1:0];
    end
  end

  // Datapath: operand capture, iteration, HI/LO writes and completion pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      HI        <= '0;
      LO        <= '0;
      magA      <= '0;
      magB      <= '0;
      acc       <= '0;
      count     <= '0;
      isDiv     <= 1'b0;
      divZero   <= 1'b0;
      negResult <= 1'b0;
      negRem    <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      if (!Flush) begin
        case (state)
          IDLE: if (Start) begin
            if (Op == 3'd4) HI <= OperandA;
            if (Op == 3'd5) LO <= OperandA;
            if (opMul || opDiv) begin
              magA      <= divZeroIn ? OperandA : absA;
              magB      <= absB;
              acc       <= {{W{1'b0}}, (opDiv ? absA : absB)};
              count     <= CW'(W);
              isDiv     <= opDiv;
              divZero   <= divZeroIn;
              negResult <= signA ^ signB;
              negRem    <= signA;
            end
          end
          ITER: begin
            acc   <= accStep;
            count <= count - CW'(1);
          end
          FIX: begin
            HI        <= hiNext;
            LO        <= loNext;
            Done      <= 1'b1;
            DivByZero <= divZero;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (W=32).
// Expected latencies follow MDU_FAST_MUL_EN when it is defined for the build.
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = W + 1;
`endif
  localparam int DivLat = W + 1;

  logic         clock, reset_n, Start, HiLoRead, Flush;
  logic [2:0]   Op;
  logic [W-1:0] OperandA, OperandB;
  logic         Busy, Stall, Done, DivByZero;
  logic [W-1:0] HI, LO;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .HiLoRead(HiLoRead), .Flush(Flush),
    .Busy(Busy), .Stall(Stall), .Done(Done), .DivByZero(DivByZero),
    .HI(HI), .LO(LO)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one edge (edge E); returns 1ns after E.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge clock); #1;
    Start = 1'b0; Op = 3'd7;
  endtask

  // Count edges after E until Done is seen (0 = never within bound) and Busy cycles before it.
  task automatic waitDone(output int lat, output int busyCyc, output logic dz);
    lat = 0; busyCyc = int'(Busy); dz = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (Done) begin
        lat = n; dz = DivByZero;
        break;
      end
      busyCyc += int'(Busy);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expHi,
                       input logic [W-1:0] expLo, input int expLat, input logic expDz);
    int lat, busyCyc;
    logic dz;
    issue(op, a, b);
    waitDone(lat, busyCyc, dz);
    check({tag, "_hi"}, HI, expHi);
    check({tag, "_lo"}, LO, expLo);
    check({tag, "_latency"}, lat, expLat);
    check({tag, "_busy_cycles"}, busyCyc, expLat);
    check({tag, "_divbyzero"}, dz, expDz);
  endtask

  initial begin
    int stallBad, doneSeen, doneCnt;
    reset_n = 1'b0; Start = 1'b0; Op = 3'd7; OperandA = '0; OperandB = '0;
    HiLoRead = 1'b0; Flush = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_stall", Stall, 0);
    check("rst_done", Done, 0);
    check("rst_dbz", DivByZero, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    @(posedge clock); #1;

    runOp("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MulLat, 1'b0);
    runOp("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MulLat, 1'b0);

    // MTHI / MTLO: written at the accepting edge, no Busy, no Done.
    issue(3'd4, 32'hA5A5_A5A5, 32'h0);
    check("mthi_hi", HI, 32'hA5A5_A5A5);
    check("mthi_lo_kept", LO, 32'hFFFF_FFF1);
    check("mthi_busy", Busy, 0);
    check("mthi_done", Done, 0);
    issue(3'd5, 32'h5A5A_5A5A, 32'h0);
    check("mtlo_lo", LO, 32'h5A5A_5A5A);
    check("mtlo_busy", Busy, 0);

    runOp("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat, 1'b0);
    runOp("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DivLat, 1'b0);
    runOp("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, DivLat, 1'b0);
    // Issued in the Done cycle of the previous op: must be accepted immediately.
    runOp("b2b_divu", 3'd3, 32'd9, 32'd4, 32'd1, 32'd2, DivLat, 1'b0);
    runOp("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DivLat, 1'b0);
    runOp("divu_zero", 3'd3, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1, 1'b1);
    @(posedge clock); #1;
    check("dbz_done_clear", Done, 0);
    check("dbz_flag_clear", DivByZero, 0);

    // Stall: MFHI/MFLO and a second Start held against an in-flight DIV.
    issue(3'd2, 32'd100, 32'd7);
    repeat (4) begin @(posedge clock); #1; end
    HiLoRead = 1'b1; #1;
    check("stall_read", Stall, 1);
    Start = 1'b1; Op = 3'd1; OperandA = 32'd3; OperandB = 32'd3; #1;
    check("stall_start", Stall, 1);
    @(posedge clock); #1;
    Start = 1'b0; Op = 3'd7;
    stallBad = 0; doneSeen = 0;
    for (int n = 0; n < 100; n++) begin
      if (Done) begin doneSeen = 1; break; end
      if (Stall !== 1'b1) stallBad++;
      @(posedge clock); #1;
    end
    check("stall_while_busy", stallBad, 0);
    check("stall_done_seen", doneSeen, 1);
    check("stall_at_done", Stall, 0);
    check("stall_div_lo", LO, 32'd14);
    check("stall_div_hi", HI, 32'd2);
    HiLoRead = 1'b0;
    @(posedge clock); #1;
    check("busy_start_ignored", Busy, 0);

    // Flush mid-DIV: aborts without touching HI/LO or pulsing Done.
    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clock); #1; end
    Flush = 1'b1;
    @(posedge clock); #1;
    Flush = 1'b0;
    check("flush_busy", Busy, 0);
    doneCnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      doneCnt += int'(Done);
    end
    check("flush_no_done", doneCnt, 0);
    check("flush_hi", HI, 32'd2);
    check("flush_lo", LO, 32'd14);
    // Start coincident with Flush in IDLE is dropped.
    Flush = 1'b1;
    issue(3'd4, 32'hDEAD_BEEF, 32'h0);
    Flush = 1'b0;
    check("flush_start_hi", HI, 32'd2);

    // Asynchronous reset mid-MULT clears everything without waiting for an edge.
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    HiLoRead = 1'b1; #1;
    check("pre_rst_busy", Busy, 1);
    reset_n = 1'b0; #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_stall", Stall, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_hi", HI, 0);
    check("mid_rst_lo", LO, 0);
    HiLoRead = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_busy", Busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
